// File: rtl/ram_loader_pkg.sv
// ============================================================================
// ram_loader_pkg : shared types, sizes and word-count clamp for the loader
// Revision 1.0
// ============================================================================
`default_nettype none

package ram_loader_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int CNT_W  = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD_HI = 4'd1,
    ST_LOAD_LO = 4'd2,
    ST_WRITE   = 4'd3,
    ST_VRD     = 4'd4,
    ST_VWAIT   = 4'd5,
    ST_VCAP    = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_e;

  // A request of 0 or anything beyond the RAM means "fill the whole RAM".
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] wc);
    if ((wc == '0) || (wc > CNT_W'(DEPTH))) begin
      return CNT_W'(DEPTH);
    end
    return wc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_loader_16x128_if.sv
// ============================================================================
// ram_loader_16x128_if : host byte link, RAM port and status of the loader
// Revision 1.0
// ============================================================================
`default_nettype none

interface ram_loader_16x128_if;
  import ram_loader_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  word_count;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              ram_read_en;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  // The loader owns the RAM port, so it is the master side.
  modport master (
    input  start, word_count, rx_data, rx_valid, ram_dout,
    output rx_ready, ram_read_en, ram_write_en, ram_addr, ram_din,
           busy, done, error, checksum
  );

  modport slave (
    output start, word_count, rx_data, rx_valid, ram_dout,
    input  rx_ready, ram_read_en, ram_write_en, ram_addr, ram_din,
           busy, done, error, checksum
  );

endinterface

`default_nettype wire

// File: rtl/ram_loader_16x128_byte_pair_assembler.sv
// ============================================================================
// byte_pair_assembler : packs two accepted bytes (high first) into one word
// Revision 1.0
// ============================================================================
`default_nettype none

module byte_pair_assembler
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_en_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              hi_accept_o,
  output logic              word_valid_o,
  output logic [DATA_W-1:0] word_o
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic       w_fire;

  assign rx_ready_o   = load_en_i;
  assign w_fire       = rx_valid_i && load_en_i;
  assign hi_accept_o  = w_fire && !phase_q;
  assign word_valid_o = w_fire && phase_q;
  assign word_o       = {hi_q, lo_q};

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (clear_i) begin
      phase_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
    end else if (w_fire) begin
      if (!phase_q) begin
        hi_d = rx_data_i;
      end else begin
        lo_d = rx_data_i;
      end
      phase_d = !phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_loader_16x128.sv
// ============================================================================
// ram_loader_16x128 : loads a byte stream into the 16x128 program RAM and
//                     verifies it by reading back against a 16-bit sum
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_loader_16x128
  import ram_loader_pkg::*;
#(
  parameter int RD_LAT = 1
)
(
  input  logic                clk,
  input  logic                rst,
  ram_loader_16x128_if.master bus
);

  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] readsum_q, readsum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wait_q, wait_d;

  logic              w_rd;
  logic              w_wr;
  logic              w_clear;
  logic              w_last;
  logic              w_load_en;
  logic              w_hi_accept;
  logic              w_word_valid;
  logic [DATA_W-1:0] w_word;

  assign w_load_en = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
  assign w_last    = ({1'b0, index_q} == (n_q - CNT_W'(1)));

  byte_pair_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_clear),
    .load_en_i    (w_load_en),
    .rx_data_i    (bus.rx_data),
    .rx_valid_i   (bus.rx_valid),
    .rx_ready_o   (bus.rx_ready),
    .hi_accept_o  (w_hi_accept),
    .word_valid_o (w_word_valid),
    .word_o       (w_word)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    n_d        = n_q;
    checksum_d = checksum_q;
    readsum_d  = readsum_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_clear    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d    = ST_LOAD_HI;
          index_d    = '0;
          n_d        = clamp_count(bus.word_count);
          checksum_d = '0;
          readsum_d  = '0;
          w_clear    = 1'b1;
        end
      end
      ST_LOAD_HI: begin
        if (w_hi_accept) state_d = ST_LOAD_LO;
      end
      ST_LOAD_LO: begin
        if (w_word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        w_wr       = 1'b1;
        addr_d     = index_q;
        checksum_d = checksum_q + w_word;
        if (w_last) begin
          index_d = '0;
          state_d = ST_VRD;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = ST_LOAD_HI;
        end
      end
      ST_VRD: begin
        w_rd    = 1'b1;
        addr_d  = index_q;
        wait_d  = WAIT_INIT;
        state_d = (RD_LAT > 1) ? ST_VWAIT : ST_VCAP;
      end
      ST_VWAIT: begin
        if (wait_q == 2'd0) begin
          state_d = ST_VCAP;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_VCAP: begin
        readsum_d = readsum_q + bus.ram_dout;
        if (w_last) begin
          state_d = (readsum_d == checksum_q) ? ST_DONE : ST_ERR;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = ST_VRD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      n_q        <= '0;
      checksum_q <= '0;
      readsum_q  <= '0;
      addr_q     <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      n_q        <= n_d;
      checksum_q <= checksum_d;
      readsum_q  <= readsum_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
    end
  end

  // Address follows the index only while a strobe is up, otherwise it holds.
  assign bus.ram_addr     = (w_rd || w_wr) ? index_q : addr_q;
  assign bus.ram_read_en  = w_rd;
  assign bus.ram_write_en = w_wr;
  assign bus.ram_din      = w_wr ? w_word : '0;
  assign bus.checksum     = checksum_q;
  assign bus.busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));
  assign bus.done         = (state_q == ST_DONE);
  assign bus.error        = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_ram_loader_16x128.sv
// ============================================================================
// tb_ram_loader_16x128 : directed scoreboard bench for ram_loader_16x128
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_loader_16x128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_loader_16x128_if if1 ();
  ram_loader_16x128_if if3 ();

  ram_loader_16x128 #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  ram_loader_16x128 #(.RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

  logic       sel        = 1'b0;
  logic       start      = 1'b0;
  logic       corrupt    = 1'b0;
  logic [7:0] word_count = 8'd0;
  logic [7:0] rx_data    = 8'd0;
  logic       rx_valid   = 1'b0;

  assign if1.start      = start & ~sel;
  assign if1.word_count = word_count;
  assign if1.rx_data    = rx_data;
  assign if1.rx_valid   = rx_valid & ~sel;
  assign if3.start      = start & sel;
  assign if3.word_count = word_count;
  assign if3.rx_data    = rx_data;
  assign if3.rx_valid   = rx_valid & sel;

  // RAM models drive a poison value outside the single cycle the data is valid.
  logic [15:0] mem1 [128];
  logic [15:0] d1;
  logic        v1 = 1'b0;
  always @(posedge clk) begin
    if (if1.ram_write_en) mem1[if1.ram_addr] <= if1.ram_din;
    v1 <= if1.ram_read_en;
    d1 <= (corrupt && if1.ram_addr == 7'd0) ? 16'h1235 : mem1[if1.ram_addr];
  end
  assign if1.ram_dout = v1 ? d1 : 16'hDEAD;

  logic [15:0] mem3 [128];
  logic [15:0] d3a, d3b, d3c;
  logic        v3a = 1'b0, v3b = 1'b0, v3c = 1'b0;
  always @(posedge clk) begin
    if (if3.ram_write_en) mem3[if3.ram_addr] <= if3.ram_din;
    v3a <= if3.ram_read_en;
    d3a <= mem3[if3.ram_addr];
    v3b <= v3a; d3b <= d3a;
    v3c <= v3b; d3c <= d3b;
  end
  assign if3.ram_dout = v3c ? d3c : 16'hDEAD;

  logic        m_rd, m_wr, m_rx_ready, m_busy, m_done, m_err;
  logic [6:0]  m_addr;
  logic [15:0] m_din, m_cks;
  assign m_rd       = sel ? if3.ram_read_en  : if1.ram_read_en;
  assign m_wr       = sel ? if3.ram_write_en : if1.ram_write_en;
  assign m_addr     = sel ? if3.ram_addr     : if1.ram_addr;
  assign m_din      = sel ? if3.ram_din      : if1.ram_din;
  assign m_rx_ready = sel ? if3.rx_ready     : if1.rx_ready;
  assign m_busy     = sel ? if3.busy         : if1.busy;
  assign m_done     = sel ? if3.done         : if1.done;
  assign m_err      = sel ? if3.error        : if1.error;
  assign m_cks      = sel ? if3.checksum     : if1.checksum;

  int          errors = 0;
  int          checks = 0;
  logic [22:0] exp_q[$];
  int          wr_cnt, rd_cnt, exp_rd_addr;
  bit          wr_seen [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and audit the RAM port for that cycle.
  task automatic tick();
    logic [22:0] e;
    @(negedge clk);
    if (m_wr || m_rd) check("rw_exclusive", {31'd0, m_wr & m_rd}, 32'd0);
    if (m_wr) begin
      wr_cnt++;
      check("wr_once", {31'd0, wr_seen[m_addr]}, 32'd0);
      wr_seen[m_addr] = 1'b1;
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", {25'd0, m_addr}, {25'd0, e[22:16]});
        check("wr_data", {16'd0, m_din}, {16'd0, e[15:0]});
      end
    end
    if (m_rd) begin
      rd_cnt++;
      check("rd_addr", {25'd0, m_addr}, 32'(exp_rd_addr));
      exp_rd_addr++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ready);
    int n;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      if (chk_ready) check("rx_ready_wait", {31'd0, m_rx_ready}, 32'd1);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!m_rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("byte_timeout", {31'd0, m_rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [6:0] addr, input int gap, input bit chk);
    exp_q.push_back({addr, hi, lo});
    send_byte(hi, gap, 1'b0);
    send_byte(lo, gap, chk);
  endtask

  task automatic start_load(input logic [7:0] wc);
    wr_cnt = 0;
    rd_cnt = 0;
    exp_rd_addr = 0;
    for (int i = 0; i < 128; i++) wr_seen[i] = 1'b0;
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("done_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  task automatic final_checks(input logic [15:0] cks, input bit dn, input bit er, input int words);
    check("done",      {31'd0, m_done}, {31'd0, dn});
    check("error",     {31'd0, m_err},  {31'd0, er});
    check("busy_end",  {31'd0, m_busy}, 32'd0);
    check("checksum",  {16'd0, m_cks},  {16'd0, cks});
    check("wr_count",  32'(wr_cnt), 32'(words));
    check("rd_count",  32'(rd_cnt), 32'(words));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] sum;

    // Reset state of both instances
    tick();
    check("rst_busy1",  {31'd0, if1.busy},         32'd0);
    check("rst_done1",  {31'd0, if1.done},         32'd0);
    check("rst_err1",   {31'd0, if1.error},        32'd0);
    check("rst_cks1",   {16'd0, if1.checksum},     32'd0);
    check("rst_ready1", {31'd0, if1.rx_ready},     32'd0);
    check("rst_strb1",  {30'd0, if1.ram_read_en, if1.ram_write_en}, 32'd0);
    check("rst_addr3",  {25'd0, if3.ram_addr},     32'd0);
    check("rst_busy3",  {31'd0, if3.busy},         32'd0);
    rst = 1'b0;
    tick();

    // 1: two words, back-to-back bytes
    start_load(8'd2);
    check("s1_busy",  {31'd0, m_busy},     32'd1);
    check("s1_ready", {31'd0, m_rx_ready}, 32'd1);
    send_word(8'h12, 8'h34, 7'd0, 0, 1'b0);
    send_word(8'hAB, 8'hCD, 7'd1, 0, 1'b0);
    wait_idle();
    final_checks(16'hBE01, 1'b1, 1'b0, 2);

    // 2: word_count 0 loads the full RAM
    start_load(8'd0);
    sum = 16'd0;
    for (int i = 0; i < 128; i++) begin
      sum = sum + {i[7:0], i[7:0]};
      send_word(i[7:0], i[7:0], i[6:0], 0, 1'b0);
    end
    wait_idle();
    final_checks(sum, 1'b1, 1'b0, 128);

    // 3: corrupted readback of address 0
    corrupt = 1'b1;
    start_load(8'd2);
    send_word(8'h12, 8'h34, 7'd0, 0, 1'b0);
    send_word(8'hAB, 8'hCD, 7'd1, 0, 1'b0);
    wait_idle();
    final_checks(16'hBE01, 1'b0, 1'b1, 2);
    for (int i = 0; i < 5; i++) tick();
    check("s3_err_hold", {30'd0, m_err, m_busy}, 32'd2);
    corrupt = 1'b0;

    // 4: gapped rx_valid; the new start clears the sticky error
    start_load(8'd2);
    check("s4_err_clr", {31'd0, m_err}, 32'd0);
    check("s4_cks_clr", {16'd0, m_cks}, 32'd0);
    send_word(8'h12, 8'h34, 7'd0, 3, 1'b1);
    send_word(8'hAB, 8'hCD, 7'd1, 3, 1'b1);
    wait_idle();
    final_checks(16'hBE01, 1'b1, 1'b0, 2);

    // 5: asynchronous reset after three bytes, then a clean reload
    start_load(8'd2);
    send_word(8'h12, 8'h34, 7'd0, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("s5_busy",  {31'd0, m_busy},     32'd0);
    check("s5_done",  {31'd0, m_done},     32'd0);
    check("s5_cks",   {16'd0, m_cks},      32'd0);
    check("s5_ready", {31'd0, m_rx_ready}, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    start_load(8'd2);
    send_word(8'h12, 8'h34, 7'd0, 0, 1'b0);
    send_word(8'hAB, 8'hCD, 7'd1, 0, 1'b0);
    wait_idle();
    final_checks(16'hBE01, 1'b1, 1'b0, 2);

    // 6: RD_LAT=3 instance, second start while in LOAD_LO is ignored
    sel = 1'b1;
    tick();
    start_load(8'd2);
    send_word(8'h12, 8'h34, 7'd0, 0, 1'b0);
    exp_q.push_back({7'd1, 16'hABCD});
    send_byte(8'hAB, 0, 1'b0);
    word_count = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s6_busy", {31'd0, m_busy}, 32'd1);
    check("s6_cks",  {16'd0, m_cks},  32'h1234);
    send_byte(8'hCD, 0, 1'b0);
    wait_idle();
    final_checks(16'hBE01, 1'b1, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_loader_16x128.md
Name: ram_loader_16x128

Overview:
Program-RAM writer for the 16x128 instruction RAM. It takes a byte stream from a host link and packs each pair of bytes into a 16-bit word. It writes the words to consecutive RAM addresses starting at 0, then reads them back and compares a 16-bit sum checksum. It drives the RAM's read_en/write_en/addr/din port in place of the bench-side $readmemb preload.

Parameters:
DATA_W, 16, RAM word width
ADDR_W, 7, RAM address width
DEPTH, 128, RAM word count
RD_LAT, 1, cycles from ram_read_en high to valid ram_dout (1..4)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin a load
word_count  in  8  words to load; 0 or >128 means 128; latched on accepted start
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte
ram_read_en  out  1  RAM read strobe
ram_write_en  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data
busy  out  1  load or verify in progress
done  out  1  level; load finished and checksum matched
error  out  1  level; readback checksum mismatch
checksum  out  DATA_W  running sum of written words, mod 2^16

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs are 0, and the internal index, sums and byte latch are cleared. Reset mid-operation aborts immediately. Words already written remain in the RAM.
- Byte handshake: a byte transfers on a cycle where rx_valid && rx_ready. rx_ready is 1 only in LOAD_HI and LOAD_LO. rx_valid may drop at any time; the loader waits indefinitely.
- Byte order: the first byte of a pair is word[15:8], the second is word[7:0].
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, VRD, VWAIT, VCAP, DONE, ERR.
- IDLE/DONE/ERR -> LOAD_HI on start. This transition also:
  - clears done, error, checksum and index;
  - latches the clamped word count N.
- start while busy is ignored.
- LOAD_HI -> LOAD_LO on a byte transfer.
- LOAD_LO -> WRITE on a byte transfer.
- WRITE, exactly one cycle:
  - ram_write_en=1, ram_addr=index, ram_din=assembled word;
  - checksum += word (16-bit wrap);
  - if index==N-1, clear index and go to VRD; otherwise increment index and go to LOAD_HI.
- VRD, one cycle: ram_read_en=1, ram_addr=index.
  - RD_LAT=1: go to VCAP.
  - Otherwise: go to VWAIT for RD_LAT-1 cycles, then VCAP.
- VCAP: readsum += ram_dout.
  - If index==N-1: go to DONE if readsum (including this word) == checksum, else ERR.
  - Otherwise: increment index and go to VRD.
- DONE: done=1. ERR: error=1. Both hold until the next start or rst.
- busy=1 in every state except IDLE, DONE and ERR.
- ram_read_en and ram_write_en are never high together. Both are 0 outside VRD and WRITE.
- ram_addr holds the last driven value when neither strobe is high.
- ram_addr never exceeds DEPTH-1. The index compare uses N-1, so there is no wrap past 127.
- Throughput: minimum 3 cycles per word during load; 2+RD_LAT-1 cycles per word during verify.
- checksum output is valid continuously and final from the WRITE of the last word.

Decomposition:
- Shared package ram_loader_pkg:
  - state enum;
  - DATA_W/ADDR_W/DEPTH constants;
  - the word-count clamp function (0 or >DEPTH -> DEPTH).
- One natural sub-module: byte_pair_assembler. It holds the hi-byte latch and the LOAD_HI/LOAD_LO phase bit, and outputs the word plus a word_valid pulse. The top-level FSM consumes word_valid.

Test Plan:
1. start, word_count=2, bytes 0x12,0x34,0xAB,0xCD, each with rx_valid=1 -> writes addr0=0x1234 and addr1=0xABCD; checksum=0xBE01; reads addr0 and addr1; done=1, error=0, busy=0.
2. start, word_count=0, 256 bytes encoding word i = i*0x0101 -> addresses 0..127 written once each, no address >127; checksum = sum mod 2^16; done=1.
3. As scenario 1, but the bench RAM model returns 0x1235 on the addr0 readback -> error=1, done=0, state ERR until the next start.
4. rx_valid toggles 1-0-0-1 with 3-cycle gaps -> rx_ready stays 1 while waiting; exactly one write per 2 accepted bytes; same final values as scenario 1.
5. rst pulsed after 3 of the 4 bytes in scenario 1 -> all outputs 0 asynchronously; the next start with 4 fresh bytes completes with checksum 0xBE01.
6. start pulsed again during LOAD_LO, and RD_LAT=3 -> second start ignored (no checksum clear); ram_dout is sampled exactly 3 cycles after each ram_read_en; done=1.
